// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential fetch into a DEPTH-entry prefetch queue,
// halt on branch/jump until redirected. Define FETCH_BYPASS_EN for zero-latency empty-queue bypass.
module fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              enJump,
  input  logic [ADDR_W-1:0] JumpAddr,
  input  logic              enBranch,
  input  logic [ADDR_W-1:0] BranchAddr,
  output logic              DecEn,
  output logic [ADDR_W-1:0] DecPC,
  output logic [INST_W-1:0] DecInst,
  output logic              instEn,
  output logic [ADDR_W-1:0] instAddr,
  input  logic              hit,
  input  logic [INST_W-1:0] cacheInst,
  input  logic              memInstOutEn,
  input  logic [INST_W-1:0] memInst
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    WORK,
    WAITBJ
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic              inst_en_q, inst_en_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic              resp;
  logic [INST_W-1:0] resp_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic              accept;
  logic              queue_empty;
  logic              bypass;
  logic              pop;
  logic              push;
  logic [CNT_W-1:0]  count_next;
  logic              has_room;

  assign resp            = hit | memInstOutEn;
  assign resp_data       = hit ? cacheInst : memInst;
  assign redirect        = (state_q != IDLE) & (enJump | enBranch);
  assign redirect_target = enJump ? JumpAddr : BranchAddr;
  // A response only counts against an outstanding request, and never in a redirect cycle.
  assign accept          = inst_en_q & resp & ~redirect;
  assign queue_empty     = (count_q == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = accept & queue_empty & ~stall;
`else
  assign bypass = 1'b0;
`endif

  assign pop        = ~queue_empty & ~stall & ~redirect;
  assign push       = accept & ~bypass;
  assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);
  assign has_room   = (count_next < CNT_W'(DEPTH));

  assign DecEn    = pop | bypass;
  assign instEn   = inst_en_q;
  assign instAddr = inst_addr_q;

  always_comb begin
    DecPC   = '0;
    DecInst = '0;
    if (bypass) begin
      DecPC   = inst_addr_q;
      DecInst = resp_data;
    end else if (!queue_empty) begin
      DecPC   = pc_mem[head_q];
      DecInst = inst_mem[head_q];
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    inst_en_d   = inst_en_q;
    inst_addr_d = inst_addr_q;
    count_d     = count_next;
    head_d      = head_q + PTR_W'(pop);
    tail_d      = tail_q + PTR_W'(push);

    if (redirect) begin
      state_d     = WORK;
      inst_en_d   = 1'b1;
      inst_addr_d = redirect_target;
      count_d     = '0;
      head_d      = '0;
      tail_d      = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = WORK;
          inst_en_d = 1'b1;
        end
        WORK: begin
          if (accept) begin
            if (resp_data[6]) begin
              state_d   = WAITBJ;
              inst_en_d = 1'b0;
            end else begin
              inst_addr_d = inst_addr_q + ADDR_W'(4);
              inst_en_d   = has_room;
            end
          end else if (!inst_en_q) begin
            inst_en_d = has_room;
          end
        end
        WAITBJ: begin
          inst_en_d = 1'b0;
        end
        default: begin
          state_d   = IDLE;
          inst_en_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      inst_en_q   <= 1'b0;
      inst_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      inst_en_q   <= inst_en_d;
      inst_addr_q <= inst_addr_d;
    end
  end

  // NOTE: queue storage is not reset; count gates every read, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]   <= inst_addr_q;
      inst_mem[tail_q] <= resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_fetch_queue;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              enJump = 1'b0;
  logic [ADDR_W-1:0] JumpAddr = '0;
  logic              enBranch = 1'b0;
  logic [ADDR_W-1:0] BranchAddr = '0;
  logic              DecEn;
  logic [ADDR_W-1:0] DecPC;
  logic [INST_W-1:0] DecInst;
  logic              instEn;
  logic [ADDR_W-1:0] instAddr;
  logic              hit = 1'b0;
  logic [INST_W-1:0] cacheInst = '0;
  logic              memInstOutEn = 1'b0;
  logic [INST_W-1:0] memInst = '0;

  fetch_queue #(
    .ADDR_W(ADDR_W),
    .INST_W(INST_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .enJump      (enJump),
    .JumpAddr    (JumpAddr),
    .enBranch    (enBranch),
    .BranchAddr  (BranchAddr),
    .DecEn       (DecEn),
    .DecPC       (DecPC),
    .DecInst     (DecInst),
    .instEn      (instEn),
    .instAddr    (instAddr),
    .hit         (hit),
    .cacheInst   (cacheInst),
    .memInstOutEn(memInstOutEn),
    .memInst     (memInst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  // Reference model: the queue is a plain SV queue; flags track started / waiting for redirect.
  entry_t            m_q[$];
  bit                m_started;
  bit                m_wait;
  bit                m_req;
  logic [ADDR_W-1:0] m_addr;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_started = 1'b0;
    m_wait    = 1'b0;
    m_req     = 1'b0;
    m_addr    = '0;
  endtask

  // Drive one cycle of inputs, check outputs against the model, then advance the model at the edge.
  task automatic step(input bit s, input bit h, input bit m,
                      input logic [INST_W-1:0] ci, input logic [INST_W-1:0] mi,
                      input bit j, input logic [ADDR_W-1:0] ja,
                      input bit b, input logic [ADDR_W-1:0] ba);
    bit                resp_v;
    bit                redir;
    bit                accept;
    bit                byp;
    bit                dec_exp;
    logic [INST_W-1:0] data;
    logic [ADDR_W-1:0] tgt;
    stall        = s;
    hit          = h;
    memInstOutEn = m;
    cacheInst    = ci;
    memInst      = mi;
    enJump       = j;
    JumpAddr     = ja;
    enBranch     = b;
    BranchAddr   = ba;
    #2;
    resp_v = h | m;
    data   = h ? ci : mi;
    redir  = m_started && (j || b);
    tgt    = j ? ja : ba;
    accept = m_req && resp_v && !redir;
    byp    = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = accept && (m_q.size() == 0) && !s;
`endif
    dec_exp = ((m_q.size() != 0) && !s && !redir) || byp;
    check("instEn", instEn, m_req);
    check("instAddr", instAddr, m_addr);
    check("DecEn", DecEn, dec_exp);
    if (byp) begin
      check("DecPC_bypass", DecPC, m_addr);
      check("DecInst_bypass", DecInst, data);
    end else if (m_q.size() != 0) begin
      check("DecPC", DecPC, m_q[0].pc);
      check("DecInst", DecInst, m_q[0].inst);
    end else begin
      check("DecInst_empty", DecInst, '0);
    end
    @(posedge clk);
    if (!m_started) begin
      m_started = 1'b1;
      m_req     = 1'b1;
    end else if (redir) begin
      m_q.delete();
      m_addr = tgt;
      m_req  = 1'b1;
      m_wait = 1'b0;
    end else begin
      if ((m_q.size() != 0) && !s) void'(m_q.pop_front());
      if (accept) begin
        if (!byp) m_q.push_back('{pc: m_addr, inst: data});
        if (data[6]) begin
          m_wait = 1'b1;
          m_req  = 1'b0;
        end else begin
          m_addr = m_addr + 32'd4;
          m_req  = (m_q.size() < DEPTH);
        end
      end else if (!m_wait && !m_req) begin
        m_req = (m_q.size() < DEPTH);
      end
    end
    #1;
  endtask

  task automatic quiet(input bit s);
    step(s, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic cache_hit(input bit s, input logic [INST_W-1:0] ci);
    step(s, 1'b1, 1'b0, ci, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic jump_to(input bit s, input logic [ADDR_W-1:0] ja);
    step(s, 1'b0, 1'b0, '0, '0, 1'b1, ja, 1'b0, '0);
  endtask

  function automatic logic [INST_W-1:0] rand_inst();
    logic [INST_W-1:0] v;
    v    = $urandom;
    v[6] = ($urandom_range(7) == 0);
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_target();
    logic [ADDR_W-1:0] v;
    v = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(7) == 0) v = 32'hFFFF_FFF4;
    return v;
  endfunction

  initial begin
    model_reset();
    #2;
    check("rst_DecEn", DecEn, 1'b0);
    check("rst_instEn", instEn, 1'b0);
    check("rst_instAddr", instAddr, '0);
    check("rst_DecInst", DecInst, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming cache hits from reset.
    for (int i = 0; i < 8; i++) cache_hit(1'b0, 32'h0000_0013);

    // Decoder stall with continuous hits: queue fills, fetch halts at 0x10.
    jump_to(1'b0, 32'h0);
    for (int i = 0; i < 10; i++) cache_hit(1'b1, 32'h0000_0013);
    check("full_instAddr", instAddr, 32'h10);
    check("full_instEn", instEn, 1'b0);
    for (int i = 0; i < 6; i++) cache_hit(1'b0, 32'h0000_0013);

    // JAL at PC 8 halts fetch until a jump redirect.
    jump_to(1'b0, 32'h0);
    cache_hit(1'b0, 32'h0000_0013);
    cache_hit(1'b0, 32'h0000_0013);
    cache_hit(1'b0, 32'h0000_006F);
    for (int i = 0; i < 5; i++) quiet(1'b0);
    check("bj_instEn", instEn, 1'b0);
    jump_to(1'b0, 32'h100);
    check("jump_instAddr", instAddr, 32'h100);
    check("jump_instEn", instEn, 1'b1);
    for (int i = 0; i < 3; i++) cache_hit(1'b0, 32'h0000_0013);

    // Jump beats branch; the coincident memory response is dropped.
    step(1'b0, 1'b0, 1'b1, '0, 32'h0000_0013, 1'b1, 32'h200, 1'b1, 32'h300);
    check("jb_instAddr", instAddr, 32'h200);
    quiet(1'b0);

    // Cache wins over memory when both respond.
    step(1'b1, 1'b1, 1'b1, 32'h11, 32'h22, 1'b0, '0, 1'b0, '0);
    check("hit_priority", DecInst, 32'h11);
    quiet(1'b0);
    quiet(1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit                s, h, m, j, b;
      logic [INST_W-1:0] ci, mi;
      logic [ADDR_W-1:0] ja, ba;
      s  = ($urandom_range(3) == 0);
      h  = ($urandom_range(1) == 1);
      m  = ($urandom_range(3) == 0);
      ci = rand_inst();
      mi = rand_inst();
      j  = m_wait ? ($urandom_range(2) == 0) : ($urandom_range(40) == 0);
      b  = m_wait ? ($urandom_range(2) == 0) : ($urandom_range(40) == 0);
      ja = rand_target();
      ba = rand_target();
      step(s, h, m, ci, mi, j, ja, b, ba);
    end

    // Asynchronous reset mid-cycle with three entries queued and a request outstanding.
    jump_to(1'b1, 32'h0);
    for (int i = 0; i < 3; i++) cache_hit(1'b1, 32'h0000_0013);
    check("pre_rst_instEn", instEn, 1'b1);
    stall = 1'b1;
    hit   = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("arst_DecEn", DecEn, 1'b0);
    check("arst_instEn", instEn, 1'b0);
    check("arst_instAddr", instAddr, '0);
    check("arst_DecInst", DecInst, '0);
    model_reset();
    #1;
    rst = 1'b0;
    quiet(1'b0);
    check("refetch_instAddr", instAddr, 32'h0);
    check("refetch_instEn", instEn, 1'b1);
    for (int i = 0; i < 6; i++) cache_hit(1'b0, 32'h0000_0013);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end with a DEPTH-entry prefetch queue between the instruction source (I-cache hit path or memory controller) and the decoder. It issues sequential fetch requests while the queue has room, absorbs decoder stalls without dropping fetches, and halts on any branch/jump (opcode bit 6 set) until the execute stage supplies the redirect target. It sits between the cache/memory interface and the decoder.

## Interface
- `ADDR_W`, 32: instruction address width.
- `INST_W`, 32: instruction width.
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `stall`  in  1: decoder cannot accept this cycle.
- `enJump` / `JumpAddr`  in  1 / ADDR_W: jump redirect and target.
- `enBranch` / `BranchAddr`  in  1 / ADDR_W: branch redirect and target.
- `DecEn`  out  1: DecPC/DecInst valid; consumed at the edge when high.
- `DecPC`  out  ADDR_W: PC of the presented instruction.
- `DecInst`  out  INST_W: presented instruction.
- `instEn`  out  1: fetch request, held until a response arrives.
- `instAddr`  out  ADDR_W: fetch address, stable while instEn is high.
- `hit` / `cacheInst`  in  1 / INST_W: cache response.
- `memInstOutEn` / `memInst`  in  1 / INST_W: memory response.

## Operation
- States: IDLE (after reset), WORK, WAITBJ. IDLE -> WORK on the first edge after reset release, with instEn <= 1.
- Response = `hit | memInstOutEn`. When both are high, `hit` wins (data = cacheInst).
- A response while instEn=1 writes {instAddr, data} to the queue tail. It is ignored when instEn=0.
- After a response in WORK:
  - If data[6]=1, go to WAITBJ with instEn <= 0.
  - Else instAddr <= instAddr+4, and instEn <= (count_next < DEPTH).
- WORK with instEn=0 and count_next < DEPTH: instEn <= 1 at the current instAddr.
- Pop: DecEn = (count != 0) & ~stall. DecPC/DecInst are the head entry. A pop and a push in the same cycle leave count unchanged.
- Redirect: enJump has priority over enBranch. It is honoured in WORK and WAITBJ and does all of the following:
  - flushes the queue (count <= 0);
  - sets instAddr <= target and instEn <= 1;
  - goes to WORK.
- Redirect side effects:
  - A response in the redirect cycle is discarded.
  - DecEn is forced low in the redirect cycle.
- WAITBJ without redirect: instEn stays 0. Queued entries, including the BJ itself, continue to drain.
- count is $clog2(DEPTH)+1 bits; pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. instAddr+4 wraps modulo 2^ADDR_W.
- Full: no push can occur, because instEn is never high when count_next = DEPTH.

## Timing
- Reset (async, all flops):
  - state=IDLE, count=0, pointers=0, instEn=0, instAddr=0.
  - DecEn=0, DecInst reads 0 while the queue is empty.
- Reset mid-request drops the request and queue contents immediately.
- Fetch latency, without bypass: response at edge N, DecEn high in cycle N+1 if ~stall.
- Back-to-back cache hits sustain one instruction per cycle with ~stall.
- Redirect accepted at edge N: instEn=1 with instAddr=target during cycle N+1.
- stall has no effect on fetching until the queue fills.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When count=0, ~stall, no redirect, and a valid response arrives, DecEn=1 that same cycle.
  - DecPC/DecInst come combinationally from instAddr and the response data.
  - The entry is not written to the queue.
  - Zero-cycle fetch-to-decode latency.
- Not defined: every instruction passes through the queue, with a minimum one-cycle latency.

## Test plan
- Reset release, then a cache hit every cycle on non-BJ data 0x00000013, stall=0:
  - instAddr steps 0,4,8,...;
  - DecEn continuous from cycle 2 (cycle 1 with bypass);
  - DecPC follows instAddr.
- stall=1 for 10 cycles with DEPTH=4 and continuous hits:
  - exactly 4 entries buffered; instEn low while full, instAddr=0x10;
  - after stall release, PCs 0,4,8,0xC then 0x10 are decoded with none lost or duplicated.
- Fetch 0x0000006F (JAL) at PC 8:
  - instEn drops and state is WAITBJ;
  - after 5 idle cycles, enJump=1 with JumpAddr=0x100 gives instAddr=0x100 next cycle;
  - the decoder sees PC 8 before PC 0x100.
- enJump (0x200) and enBranch (0x300) in the same cycle as a memory response:
  - instAddr=0x200 and the response is discarded;
  - the queue is empty the next cycle.
- hit and memInstOutEn together with cacheInst=0x11, memInst=0x22: the queued instruction is 0x11.
- Async rst pulsed mid-cycle with 3 entries queued and instEn=1:
  - outputs reach their reset values before the next edge;
  - refetch restarts from PC 0.
